// File: rtl/spi_tx_engine_if.sv
// Signal bundle between the SPI shift engine and its register/pad environment.
// master = the engine itself; slave = register block, slave device and pads.
interface spi_tx_engine_if #(
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] tx_data;
  logic              start;
  logic              MISO;
  logic              SCLK;
  logic              MOSI;
  logic              CS_n;
  logic              busy;
  logic              done;
  logic [DWIDTH-1:0] rx_data;

  modport master (
    input  tx_data, start, MISO,
    output SCLK, MOSI, CS_n, busy, done, rx_data
  );

  modport slave (
    output tx_data, start, MISO,
    input  SCLK, MOSI, CS_n, busy, done, rx_data
  );
endinterface

// File: rtl/spi_tx_engine.sv
// SPI mode-0 master: shifts tx_data out MSB-first, captures MISO; done pulses (2*DWIDTH+2)*CLK_DIV cycles after start.
// No backpressure: start is only taken in IDLE and ignored while busy; all outputs registered.
module spi_tx_engine #(
  parameter int DWIDTH  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  spi_tx_engine_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;

  localparam int DIVW = $clog2(CLK_DIV) + 1;
  localparam int BITW = $clog2(DWIDTH) + 1;

  localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(CLK_DIV - 1);
  // TRAIL covers the last SCLK low half-period plus the CS_n hold time.
  localparam logic [DIVW-1:0] TRAIL_LAST = DIVW'(2 * CLK_DIV - 1);
  localparam logic [BITW-1:0] BIT_LAST   = BITW'(DWIDTH - 1);

  logic [1:0]        state;
  logic [DIVW-1:0]   div_cnt;
  logic [BITW-1:0]   bit_cnt;
  logic [DWIDTH-1:0] tx_sr;
  logic [DWIDTH-1:0] rx_sr;
  logic              half_done;

  assign half_done = (div_cnt == DIV_LAST);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state       <= ST_IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bus.SCLK    <= 1'b0;
      bus.MOSI    <= 1'b0;
      bus.CS_n    <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rx_data <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            tx_sr    <= bus.tx_data;
            bus.MOSI <= bus.tx_data[DWIDTH-1];
            bus.CS_n <= 1'b0;
            bus.busy <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          // The end of the setup interval is also the first SCLK rise.
          if (half_done) begin
            div_cnt  <= '0;
            bus.SCLK <= 1'b1;
            rx_sr    <= {rx_sr[DWIDTH-2:0], bus.MISO};
            state    <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (half_done) begin
            div_cnt <= '0;
            if (!bus.SCLK) begin
              bus.SCLK <= 1'b1;
              rx_sr    <= {rx_sr[DWIDTH-2:0], bus.MISO};
            end else begin
              bus.SCLK <= 1'b0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
                state <= ST_TRAIL;
              end else begin
                tx_sr    <= tx_sr << 1;
                bus.MOSI <= tx_sr[DWIDTH-2];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_TRAIL: begin
          if (div_cnt == TRAIL_LAST) begin
            bus.CS_n    <= 1'b1;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.rx_data <= rx_sr;
            bus.MOSI    <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
